// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and constants for the A-stage multiply/divide sequencer.
// The divider is only built when MULDIV_DIV_EN is defined.
package muldiv_pkg;
  localparam int DATA_W = 32;

  localparam logic [5:0] OP_MUL  = 6'b000010;
  localparam logic [5:0] OP_MULH = 6'b000011;
  localparam logic [5:0] OP_DIV  = 6'b000100;
  localparam logic [5:0] OP_DIVU = 6'b000101;
  localparam logic [5:0] OP_REM  = 6'b000110;
  localparam logic [5:0] OP_REMU = 6'b000111;

  localparam int DIV_ITERS = 32;
  localparam int ITER_W    = $clog2(DIV_ITERS);
  localparam int CNT_W     = 4;

  localparam logic [DATA_W-1:0] DIV0_QUO   = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] OVF_QUO    = 32'h8000_0000;
  localparam logic [DATA_W-1:0] OVF_REM    = 32'h0000_0000;
  localparam logic [DATA_W-1:0] SIGNED_MIN = 32'h8000_0000;
  localparam logic [DATA_W-1:0] NEG_ONE    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes: the dividend
// bits shift out of the quotient register while quotient bits shift in.
module div_step
  import muldiv_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            fits;

  // rem < dvs always holds, so a set top bit of diff means the trial subtraction borrowed
  always_comb begin
    shifted  = {rem, quo[DATA_W-1]};
    diff     = shifted - {1'b0, dvs};
    fits     = ~diff[DATA_W];
    rem_next = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_next = {quo[DATA_W-2:0], fits};
  end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/MULH sequencer (and radix-2 DIV/REM when MULDIV_DIV_EN is defined)
// that stalls the A stage and presents its result for the cycle the A/C register captures it.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        da_ALU_Control,
  input  logic [DATA_W-1:0] alu_in1,
  input  logic [DATA_W-1:0] alu_in2,
  input  logic              dcache_stall,
  input  logic              icache_stall,
  input  logic              md_flush,
  output logic              md_stall,
  output logic              md_done,
  output logic              md_busy,
  output logic [DATA_W-1:0] md_result
);
  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic                     is_mul_op, is_div_op, is_md, start;
  logic signed [63:0]       a_ext, b_ext, prod;
  logic                     mulh_q;
  logic [DATA_W-1:0]        done_val;

  assign is_mul_op = (da_ALU_Control == OP_MUL) || (da_ALU_Control == OP_MULH);
`ifdef MULDIV_DIV_EN
  assign is_div_op = da_ALU_Control inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
`else
  assign is_div_op = 1'b0;
`endif
  assign is_md = is_mul_op || is_div_op;
  assign start = (state == IDLE) && is_md && !md_flush;
  assign a_ext = {{32{alu_in1[DATA_W-1]}}, alu_in1};
  assign b_ext = {{32{alu_in2[DATA_W-1]}}, alu_in2};

`ifdef MULDIV_DIV_EN
  logic [ITER_W-1:0] iter;
  logic [DATA_W-1:0] div_rem, div_quo, div_dvs, rem_nxt, quo_nxt, special_val;
  logic              div_signed, div_zero, div_ovf, div_special, rem_q, neg_q, neg_r;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Bit 0 of the op code selects unsigned, bit 1 selects remainder
  assign div_signed  = ~da_ALU_Control[0];
  assign div_zero    = (alu_in2 == '0);
  assign div_ovf     = div_signed && (alu_in1 == SIGNED_MIN) && (alu_in2 == NEG_ONE);
  assign div_special = div_zero || div_ovf;
  assign special_val = div_zero ? (da_ALU_Control[1] ? alu_in1 : DIV0_QUO)
                                : (da_ALU_Control[1] ? OVF_REM : OVF_QUO);

  div_step u_div_step (
    .rem      (div_rem),
    .quo      (div_quo),
    .dvs      (div_dvs),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  always_ff @(posedge clock) begin
    if (start) begin
      rem_q   <= da_ALU_Control[1];
      neg_q   <= div_signed && (alu_in1[DATA_W-1] ^ alu_in2[DATA_W-1]);
      neg_r   <= div_signed && alu_in1[DATA_W-1];
      div_rem <= '0;
      div_quo <= magnitude(alu_in1, div_signed);
      div_dvs <= magnitude(alu_in2, div_signed);
    end else if (state == DIV) begin
      div_rem <= rem_nxt;
      div_quo <= quo_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    if (md_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (is_md) begin
`ifdef MULDIV_DIV_EN
          if (is_mul_op)        state_nxt = MUL;
          else if (div_special) state_nxt = DONE;
          else                  state_nxt = DIV;
`else
          state_nxt = MUL;
`endif
        end
        MUL: if (cnt == CNT_W'(1)) state_nxt = DONE;
`ifdef MULDIV_DIV_EN
        DIV: if (iter == ITER_W'(DIV_ITERS - 1)) state_nxt = DONE;
`endif
        DONE: if (!(dcache_stall || icache_stall)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    md_stall = is_md && (state != DONE) && !md_flush;
    md_busy  = (state == MUL) || (state == DIV);
    md_done  = (state == DONE);
  end

  // Value loaded into md_result on the edge that enters DONE
  always_comb begin
    done_val = md_result;
    case (state)
      MUL: done_val = mulh_q ? prod[63:32] : prod[31:0];
`ifdef MULDIV_DIV_EN
      DIV:  done_val = rem_q ? apply_sign(rem_nxt, neg_r) : apply_sign(quo_nxt, neg_q);
      IDLE: done_val = special_val;
`endif
      default: ;
    endcase
  end

  // Operand capture stage: product registered at accept
  always_ff @(posedge clock) begin
    if (start) begin
      mulh_q <= (da_ALU_Control == OP_MULH);
      prod   <= a_ext * b_ext;
    end
  end

  // Control and result register
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      md_result <= '0;
`ifdef MULDIV_DIV_EN
      iter      <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (start && is_mul_op)
        cnt <= CNT_W'(MUL_LATENCY - 1);
      else if (state == MUL && cnt != CNT_W'(1))
        cnt <= cnt - 1'b1;
`ifdef MULDIV_DIV_EN
      if (start)
        iter <= '0;
      else if (state == DIV)
        iter <= iter + 1'b1;
`endif
      if (state_nxt == DONE && state != DONE)
        md_result <= done_val;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results queued at issue, checked on DONE entry.
// Divide tests are compiled only when MULDIV_DIV_EN is defined.
module tb_muldiv_seq;
  localparam int L = 4;
  localparam logic [5:0] NOP     = 6'b000000;
  localparam logic [5:0] OP_MUL  = 6'b000010;
  localparam logic [5:0] OP_MULH = 6'b000011;
  localparam logic [5:0] OP_DIV  = 6'b000100;
  localparam logic [5:0] OP_DIVU = 6'b000101;
  localparam logic [5:0] OP_REM  = 6'b000110;
  localparam logic [5:0] OP_REMU = 6'b000111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  da = NOP;
  logic [31:0] in1 = '0, in2 = '0;
  logic        dcache_stall = 1'b0, icache_stall = 1'b0, md_flush = 1'b0;
  logic        md_stall, md_done, md_busy;
  logic [31:0] md_result;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic        prev_done = 1'b0;
  logic [31:0] held = '0;

  muldiv_seq #(.MUL_LATENCY(L)) dut (
    .clock          (clock),
    .reset          (reset),
    .da_ALU_Control (da),
    .alu_in1        (in1),
    .alu_in2        (in2),
    .dcache_stall   (dcache_stall),
    .icache_stall   (icache_stall),
    .md_flush       (md_flush),
    .md_stall       (md_stall),
    .md_done        (md_done),
    .md_busy        (md_busy),
    .md_result      (md_result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Scoreboard: pop on DONE entry, then require the result to hold while DONE persists
  always @(negedge clock) begin : monitor
    exp_t e;
    if (md_done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, " result"}, md_result, e.val);
      end
      held = md_result;
    end else if (md_done) begin
      check("result_hold", md_result, held);
    end
    prev_done = md_done;
  end

  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int cs, input bit use_ic);
    int   cyc = 0;
    int   stalls = 0;
    int   done_cyc = 0;
    exp_t e;
    step();
    e.tag = tag;
    e.val = exp;
    exp_q.push_back(e);
    da = op; in1 = a; in2 = b;
    #1;
    check({tag, " idle_at_issue"}, {md_busy, md_done}, 0);
    while (!md_done && cyc < 100) begin
      if (md_stall) stalls++;
      cyc++;
      step();
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " stall_cycles"}, stalls, lat);
    check({tag, " done_no_stall"}, md_stall, 0);
    for (int k = 0; k <= cs; k++) begin
      if (md_done) done_cyc++;
      if (k < cs) begin
        if (use_ic) icache_stall = 1'b1;
        else        dcache_stall = 1'b1;
        step();
      end
    end
    dcache_stall = 1'b0;
    icache_stall = 1'b0;
    da = NOP;
    check({tag, " done_cycles"}, done_cyc, cs + 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, hi;
    logic [63:0] up;
    int          seen;

    repeat (3) step();
    check("reset md_done", md_done, 0);
    check("reset md_busy", md_busy, 0);
    check("reset md_stall", md_stall, 0);
    check("reset md_result", md_result, 0);
    reset = 1'b0;

    run_op("mul 7x6", OP_MUL, 7, 6, 42, L, 0, 0);
    run_op("mul -3x5", OP_MUL, 32'hFFFF_FFFD, 5, 32'hFFFF_FFF1, L, 0, 0);
    run_op("mulh min x2", OP_MULH, 32'h8000_0000, 2, 32'hFFFF_FFFF, L, 0, 0);
    run_op("mulh max sq", OP_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, L, 0, 0);
    run_op("mul dcache", OP_MUL, 123, 1000, 123000, L, 3, 0);
    run_op("mulh icache", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, L, 2, 1);

    // Signed high word from the unsigned product minus the sign corrections
    for (int r = 0; r < 4; r++) begin
      ra = $urandom;
      rb = $urandom;
      up = {32'b0, ra} * {32'b0, rb};
      hi = up[63:32] - (ra[31] ? rb : 32'd0) - (rb[31] ? ra : 32'd0);
      run_op("rand mul", OP_MUL, ra, rb, up[31:0], L, 0, 0);
      run_op("rand mulh", OP_MULH, ra, rb, hi, L, 0, 0);
    end

    // Flush mid-MUL: stall drops with the flush, no result follows
    step();
    da = OP_MUL; in1 = 9; in2 = 9;
    step(); step();
    check("flush busy_before", md_busy, 1);
    md_flush = 1'b1;
    #1;
    check("flush stall", md_stall, 0);
    step();
    md_flush = 1'b0;
    da = NOP;
    check("flush idle", {md_busy, md_done}, 0);
    seen = 0;
    repeat (8) begin
      step();
      if (md_done) seen++;
    end
    check("flush no_done", seen, 0);

    // Reset mid-MUL after a known nonzero result
    run_op("mul 5x5", OP_MUL, 5, 5, 25, L, 0, 0);
    step();
    da = OP_MUL; in1 = 3; in2 = 3;
    step(); step();
    reset = 1'b1;
    da = NOP;
    step();
    check("midrst busy", md_busy, 0);
    check("midrst done", md_done, 0);
    check("midrst stall", md_stall, 0);
    check("midrst result", md_result, 0);
    reset = 1'b0;
    run_op("mul after reset", OP_MUL, 6, 7, 42, L, 0, 0);

`ifdef MULDIV_DIV_EN
    run_op("div -20/3", OP_DIV, 32'hFFFF_FFEC, 3, 32'hFFFF_FFFA, 33, 0, 0);
    run_op("rem -20/3", OP_REM, 32'hFFFF_FFEC, 3, 32'hFFFF_FFFE, 33, 0, 0);
    run_op("div 20/-3", OP_DIV, 20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 0, 0);
    run_op("rem 20/-3", OP_REM, 20, 32'hFFFF_FFFD, 2, 33, 0, 0);
    run_op("divu 100/0", OP_DIVU, 100, 0, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("rem 7/0", OP_REM, 7, 0, 7, 1, 0, 0);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0, 0);
    run_op("divu big/2", OP_DIVU, 32'hFFFF_FFFF, 2, 32'h7FFF_FFFF, 33, 0, 0);
    run_op("remu 100/7", OP_REMU, 100, 7, 2, 33, 0, 0);
    run_op("divu min/-1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 2, 0);

    // Flush at iteration 10 of a divide
    step();
    da = OP_DIV; in1 = 1000; in2 = 7;
    repeat (11) step();
    check("divflush busy_before", md_busy, 1);
    md_flush = 1'b1;
    #1;
    check("divflush stall", md_stall, 0);
    step();
    md_flush = 1'b0;
    da = NOP;
    check("divflush idle", {md_busy, md_done}, 0);
    seen = 0;
    repeat (40) begin
      step();
      if (md_done) seen++;
    end
    check("divflush no_done", seen, 0);
`else
    // Divide ops are plain ALU ops in this build
    step();
    da = OP_DIV; in1 = 20; in2 = 3;
    seen = 0;
    repeat (6) begin
      #1;
      if (md_stall || md_busy || md_done) seen++;
      step();
    end
    check("nodiv div_ignored", seen, 0);
    da = OP_REMU;
    seen = 0;
    repeat (6) begin
      #1;
      if (md_stall || md_busy || md_done) seen++;
      step();
    end
    check("nodiv remu_ignored", seen, 0);
    da = NOP;
    run_op("mul after div op", OP_MUL, 11, 12, 132, L, 0, 0);
`endif

    repeat (3) step();
    check("queue empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
